// File: rtl/vec_mem_seq.sv
// Vector memory access sequencer.
// Splits one vector load/store into NBEATS beats of four strided lane
// accesses toward a 4-port memory, and gathers load lanes into ld_data.
module vec_mem_seq #(
  parameter int WIDTH  = 32,
  parameter int NBEATS = 4,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      is_store,
  input  logic [WIDTH-1:0]          base_addr,
  input  logic [WIDTH-1:0]          stride,
  input  logic [WIDTH*4*NBEATS-1:0] st_data,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH*4*NBEATS-1:0] ld_data,
  output logic                      mem_we,
  output logic [WIDTH-1:0]          mem_addr1,
  output logic [WIDTH-1:0]          mem_addr2,
  output logic [WIDTH-1:0]          mem_addr3,
  output logic [WIDTH-1:0]          mem_addr4,
  output logic [WIDTH-1:0]          mem_wd1,
  output logic [WIDTH-1:0]          mem_wd2,
  output logic [WIDTH-1:0]          mem_wd3,
  output logic [WIDTH-1:0]          mem_wd4,
  input  logic [WIDTH-1:0]          mem_rd1,
  input  logic [WIDTH-1:0]          mem_rd2,
  input  logic [WIDTH-1:0]          mem_rd3,
  input  logic [WIDTH-1:0]          mem_rd4
);

  localparam int VW = WIDTH * 4 * NBEATS;
  localparam int BW = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_reg;
  logic [BW-1:0]    beat_reg;
  logic             is_store_reg;
  logic [WIDTH-1:0] stride4_reg;
  logic [VW-1:0]    st_buf_reg;   // store elements of the beats not yet driven
  logic             we_reg;
  logic [VW-1:0]    ld_data_reg;
  logic [WIDTH-1:0] addr_reg [4];
  logic [WIDTH-1:0] wd_reg   [4];
  logic [WIDTH-1:0] rd_lane  [4];

  logic             accept;
  logic             last_beat;
  logic             advance;
  logic             cap_en;
  logic [BW-1:0]    cap_beat;

  assign accept    = (state_reg == IDLE) && start;
  assign last_beat = (beat_reg == BW'(NBEATS - 1));
  assign advance   = (state_reg == ISSUE) && !last_beat;

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign mem_we  = we_reg;
  assign ld_data = ld_data_reg;

  assign mem_addr1 = addr_reg[0];
  assign mem_addr2 = addr_reg[1];
  assign mem_addr3 = addr_reg[2];
  assign mem_addr4 = addr_reg[3];
  assign mem_wd1   = wd_reg[0];
  assign mem_wd2   = wd_reg[1];
  assign mem_wd3   = wd_reg[2];
  assign mem_wd4   = wd_reg[3];
  assign rd_lane[0] = mem_rd1;
  assign rd_lane[1] = mem_rd2;
  assign rd_lane[2] = mem_rd3;
  assign rd_lane[3] = mem_rd4;

  // Control FSM: command latch, beat counter and store-data shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      beat_reg     <= '0;
      is_store_reg <= 1'b0;
      stride4_reg  <= '0;
      st_buf_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg    <= ISSUE;
            beat_reg     <= '0;
            is_store_reg <= is_store;
            stride4_reg  <= stride << 2;
            st_buf_reg   <= st_data >> (4 * WIDTH);
          end
        end
        ISSUE: begin
          if (last_beat) begin
            if (!is_store_reg && RD_LAT != 0) state_reg <= DRAIN;
            else                              state_reg <= DONE;
          end else begin
            beat_reg   <= beat_reg + 1'b1;
            st_buf_reg <= st_buf_reg >> (4 * WIDTH);
          end
        end
        DRAIN:   state_reg <= DONE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Shared write enable: high exactly for the store beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) we_reg <= 1'b0;
    else        we_reg <= (accept && is_store) || (advance && is_store_reg);
  end

  // Per-lane address/data registers; addresses step by 4*stride per beat
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [WIDTH-1:0] lane_off;

    // stride * gi built from a shift and an add
    assign lane_off = (((gi / 2) != 0) ? (stride << 1) : '0)
                    + (((gi % 2) != 0) ? stride : '0);

    // Lane gi: load first beat on accept, step on each further beat, else hold
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_reg[gi] <= '0;
        wd_reg[gi]   <= '0;
      end else if (accept) begin
        addr_reg[gi] <= base_addr + lane_off;
        wd_reg[gi]   <= is_store ? st_data[WIDTH*gi +: WIDTH] : '0;
      end else if (advance) begin
        addr_reg[gi] <= addr_reg[gi] + stride4_reg;
        wd_reg[gi]   <= is_store_reg ? st_buf_reg[WIDTH*gi +: WIDTH] : '0;
      end
    end
  end

  // Capture timing follows the memory read latency
  if (RD_LAT == 0) begin : g_cap_comb
    assign cap_en   = (state_reg == ISSUE) && !is_store_reg;
    assign cap_beat = beat_reg;
  end else begin : g_cap_reg
    logic          cap_valid_reg;
    logic [BW-1:0] cap_beat_reg;

    // Delay the load-beat tag by one cycle to line up with registered read data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cap_valid_reg <= 1'b0;
        cap_beat_reg  <= '0;
      end else begin
        cap_valid_reg <= (state_reg == ISSUE) && !is_store_reg;
        cap_beat_reg  <= beat_reg;
      end
    end

    assign cap_en   = cap_valid_reg;
    assign cap_beat = cap_beat_reg;
  end

  // Gather read lanes into the elements of the captured beat only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_data_reg <= '0;
    end else if (cap_en) begin
      for (int b = 0; b < NBEATS; b++) begin
        if (cap_beat == BW'(b)) begin
          for (int i = 0; i < 4; i++) begin
            ld_data_reg[WIDTH*(4*b+i) +: WIDTH] <= rd_lane[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: one registered-read instance (RD_LAT=1)
// backed by a small memory model, plus a combinational-read instance (RD_LAT=0).
module tb_vec_mem_seq;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic         start0   = 1'b0;
  logic         is_store = 1'b0;
  logic [31:0]  base     = '0;
  logic [31:0]  stride   = '0;
  logic [511:0] st_data;

  logic         busy, done, we, busy0, done0, we0;
  logic [511:0] ld, ld0;
  logic [31:0]  addr_a [4];
  logic [31:0]  wd_a   [4];
  logic [31:0]  rd_q   [4];
  logic [31:0]  addr0_a[4];
  logic [31:0]  wd0_a  [4];
  logic [31:0]  rd0    [4];

  logic [31:0]  mem [256];
  logic         mem_clr  = 1'b1;
  int           n_cmp    = 0;
  int           n_bad    = 0;
  int           done_cnt = 0;
  int           dc;

  always #5 clk = ~clk;

  vec_mem_seq #(.WIDTH(32), .NBEATS(4), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base), .stride(stride), .st_data(st_data),
    .busy(busy), .done(done), .ld_data(ld), .mem_we(we),
    .mem_addr1(addr_a[0]), .mem_addr2(addr_a[1]), .mem_addr3(addr_a[2]), .mem_addr4(addr_a[3]),
    .mem_wd1(wd_a[0]), .mem_wd2(wd_a[1]), .mem_wd3(wd_a[2]), .mem_wd4(wd_a[3]),
    .mem_rd1(rd_q[0]), .mem_rd2(rd_q[1]), .mem_rd3(rd_q[2]), .mem_rd4(rd_q[3])
  );

  vec_mem_seq #(.WIDTH(32), .NBEATS(4), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .is_store(is_store),
    .base_addr(base), .stride(stride), .st_data(st_data),
    .busy(busy0), .done(done0), .ld_data(ld0), .mem_we(we0),
    .mem_addr1(addr0_a[0]), .mem_addr2(addr0_a[1]), .mem_addr3(addr0_a[2]), .mem_addr4(addr0_a[3]),
    .mem_wd1(wd0_a[0]), .mem_wd2(wd0_a[1]), .mem_wd3(wd0_a[2]), .mem_wd4(wd0_a[3]),
    .mem_rd1(rd0[0]), .mem_rd2(rd0[1]), .mem_rd3(rd0[2]), .mem_rd4(rd0[3])
  );

  // Memory model: writes from dut, registered read for dut
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int j = 0; j < 256; j++) mem[j] <= '0;
    end else if (we) begin
      for (int i = 0; i < 4; i++) mem[addr_a[i][7:0]] <= wd_a[i];
    end
    for (int i = 0; i < 4; i++) rd_q[i] <= mem[addr_a[i][7:0]];
  end

  // Combinational read for dut0
  always_comb begin
    for (int i = 0; i < 4; i++) rd0[i] = mem[addr0_a[i][7:0]];
  end

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sd(input int e);
    case (e)
      0:       return 32'd50;
      1:       return 32'd100;
      2:       return 32'd11;
      3:       return 32'd23;
      default: return 32'(1000 + e);
    endcase
  endfunction

  function automatic logic [31:0] elem(input logic [511:0] v, input int e);
    return v[32*e +: 32];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input bit use0, input bit st, input logic [31:0] b, input logic [31:0] s);
    is_store = st;
    base     = b;
    stride   = s;
    if (use0) start0 = 1'b1;
    else      start  = 1'b1;
    tick();
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic chk_beat(input bit use0, input int k, input bit st,
                          input logic [31:0] b, input logic [31:0] s);
    logic [31:0] ea;
    for (int i = 0; i < 4; i++) begin
      ea = b + s * (4 * k + i);
      if (use0) begin
        check($sformatf("addr0_b%0d_l%0d", k, i), addr0_a[i], ea);
      end else begin
        check($sformatf("addr_b%0d_l%0d", k, i), addr_a[i], ea);
        check($sformatf("wd_b%0d_l%0d", k, i), wd_a[i], st ? sd(4 * k + i) : 32'd0);
      end
    end
    if (use0) check($sformatf("busy0_b%0d", k), 32'(busy0), 32'd1);
    else      check($sformatf("we_b%0d", k), 32'(we), 32'(st));
  endtask

  // Waits (bounded) for done; cycle n is T0+n; returns one cycle after done
  task automatic wait_done(input bit use0, input int n0, input int exp_n, input string tag);
    int n;
    n = n0;
    while (((use0 ? done0 : done) == 1'b0) && n < 30) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
    $display("txn %s base=%08h stride=%08h store=%0d done_at=T0+%0d", tag, base, stride, is_store, n);
    tick();
  endtask

  initial begin
    for (int e = 0; e < 16; e++) st_data[32*e +: 32] = sd(e);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_addr1", addr_a[0], 32'd0);
    check("rst_wd4", wd_a[3], 32'd0);
    check("rst_ld0", elem(ld, 0), 32'd0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;
    tick();

    // Store base 0 stride 1
    launch(0, 1'b1, 32'd0, 32'd1);
    chk_beat(0, 0, 1'b1, 32'd0, 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_beat(0, k, 1'b1, 32'd0, 32'd1);
    end
    tick();
    check("st_done_t5", 32'(done), 32'd1);
    check("st_we_t5", 32'(we), 32'd0);
    check("st_busy_t5", 32'(busy), 32'd1);
    $display("txn store base=00000000 stride=00000001 done_at=T0+5");
    tick();
    check("st_done_t6", 32'(done), 32'd0);
    check("st_busy_t6", 32'(busy), 32'd0);

    // Load back, RD_LAT=1
    launch(0, 1'b0, 32'd0, 32'd1);
    chk_beat(0, 0, 1'b0, 32'd0, 32'd1);
    wait_done(0, 1, 6, "ld_back_done");
    for (int e = 0; e < 16; e++) check($sformatf("ld_back_e%0d", e), elem(ld, e), sd(e));

    // Strided load base 8 stride 4, RD_LAT=1
    launch(0, 1'b0, 32'd8, 32'd4);
    chk_beat(0, 0, 1'b0, 32'd8, 32'd4);
    repeat (3) tick();
    chk_beat(0, 3, 1'b0, 32'd8, 32'd4);
    wait_done(0, 4, 6, "ld_str_done");
    check("ld_str_e0", elem(ld, 0), 32'd1008);
    check("ld_str_e1", elem(ld, 1), 32'd1012);
    check("ld_str_e2", elem(ld, 2), 32'd0);

    // Same strided load, RD_LAT=0
    launch(1, 1'b0, 32'd8, 32'd4);
    chk_beat(1, 0, 1'b0, 32'd8, 32'd4);
    wait_done(1, 1, 5, "ld0_str_done");
    check("ld0_str_e0", elem(ld0, 0), 32'd1008);
    check("ld0_str_e1", elem(ld0, 1), 32'd1012);

    // Negative stride
    launch(0, 1'b0, 32'd100, 32'hFFFF_FFFF);
    chk_beat(0, 0, 1'b0, 32'd100, 32'hFFFF_FFFF);
    wait_done(0, 1, 6, "ld_neg_done");

    // Address wrap
    launch(0, 1'b0, 32'hFFFF_FFFE, 32'd1);
    chk_beat(0, 0, 1'b0, 32'hFFFF_FFFE, 32'd1);
    wait_done(0, 1, 6, "ld_wrap_done");
    check("ld_wrap_e0", elem(ld, 0), 32'd0);
    check("ld_wrap_e2", elem(ld, 2), 32'd50);
    check("ld_wrap_e3", elem(ld, 3), 32'd100);

    // Start pulses while busy and in the done cycle are ignored
    dc = done_cnt;
    launch(0, 1'b1, 32'd128, 32'd1);
    chk_beat(0, 0, 1'b1, 32'd128, 32'd1);
    tick();
    start = 1'b1; is_store = 1'b0; base = 32'd999;
    chk_beat(0, 1, 1'b1, 32'd128, 32'd1);
    tick();
    start = 1'b0;
    chk_beat(0, 2, 1'b1, 32'd128, 32'd1);
    tick();
    chk_beat(0, 3, 1'b1, 32'd128, 32'd1);
    tick();
    check("ign_done_t5", 32'(done), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy_t6", 32'(busy), 32'd0);
    tick();
    check("ign_busy_t7", 32'(busy), 32'd0);
    check("ign_done_cnt", 32'(done_cnt - dc), 32'd1);
    check("ign_mem143", mem[143], sd(15));
    check("st_keeps_ld_e2", elem(ld, 2), 32'd50);
    $display("txn store base=00000080 stride=00000001 with ignored starts");

    // Reset during beat 2 of a store
    launch(0, 1'b1, 32'd64, 32'd1);
    chk_beat(0, 0, 1'b1, 32'd64, 32'd1);
    tick();
    tick();
    check("mid_we_pre", 32'(we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_we", 32'(we), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_addr1", addr_a[0], 32'd0);
    check("mid_ld_e2", elem(ld, 2), 32'd0);
    @(posedge clk);
    @(posedge clk);
    check("mid_mem71", mem[71], sd(7));
    check("mid_mem72", mem[72], 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    $display("txn store base=00000040 aborted by reset");
    launch(0, 1'b0, 32'd64, 32'd1);
    wait_done(0, 1, 6, "ld_post_rst_done");
    check("post_rst_e0", elem(ld, 0), 32'd50);
    check("post_rst_e7", elem(ld, 7), 32'd1007);
    check("post_rst_e8", elem(ld, 8), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_mem_seq.md
Name: vec_mem_seq

Overview:
Vector memory access sequencer for the ID-stage vector memory path. It sits directly upstream of the 4-port sum memory (shared we, four address/write-data/read-data lanes). It takes one vector load or store command and breaks it into NBEATS beats of 4 strided element accesses. It drives the memory ports each beat and, for loads, gathers the read lanes into a flat result vector.

Parameters:
WIDTH, 32, element and address width in bits
NBEATS, 4, beats per vector; vector length = 4*NBEATS elements
RD_LAT, 1, memory read latency in cycles (0 = combinational read, 1 = registered read); only 0 and 1 are legal

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe, sampled only in IDLE
is_store  input  1  1 = store, 0 = load; sampled with start
base_addr  input  WIDTH  address of element 0
stride  input  WIDTH  address step between consecutive elements, two's complement
st_data  input  WIDTH*4*NBEATS  store vector; element e = bits [WIDTH*e +: WIDTH]; sampled with start
busy  output  1  high from the cycle after an accepted start until done inclusive
done  output  1  one-cycle completion pulse
ld_data  output  WIDTH*4*NBEATS  gathered load vector, same packing as st_data
mem_we  output  1  shared write enable to memory
mem_addr1..mem_addr4  output  WIDTH each  lane addresses
mem_wd1..mem_wd4  output  WIDTH each  lane write data
mem_rd1..mem_rd4  input  WIDTH each  lane read data

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, mem_we=0, all mem_addr*/mem_wd* = 0, ld_data = 0. Takes effect immediately, mid-operation included. An in-flight command is discarded and no further beats are issued.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: when start=1 at edge T0, latch is_store, base_addr, stride and st_data, and clear the beat counter. Next state is ISSUE.
- ISSUE: lasts exactly NBEATS cycles. Beat k (k=0..NBEATS-1) is driven in cycle T0+1+k.
  - Lane i (i=0..3, port i+1): mem_addr = base + stride*(4k+i), modulo 2^WIDTH.
  - Addresses are generated incrementally with adders, not multipliers: lane base advances by 4*stride per beat.
  - Store: mem_we=1, mem_wd lane i = element 4k+i.
  - Load: mem_we=0, mem_wd = 0.
  - After the last beat: store goes to DONE; load goes to DRAIN if RD_LAT=1, otherwise to DONE.
- Load capture: mem_rd lane i for beat k is valid in cycle T0+1+k+RD_LAT. It is written into ld_data element 4k+i at the end of that cycle. Only the elements being captured change.
- DRAIN: one cycle, capturing the final beat. Next state is DONE.
- DONE: one cycle with done=1. mem_we=0 and mem_addr* hold their last values. Next state is IDLE.
- Done timing: store done in cycle T0+NBEATS+1; load done in cycle T0+NBEATS+1+RD_LAT.
- Outside ISSUE: mem_we=0. mem_addr*/mem_wd* hold last values (no glitching to X).
- ld_data holds its value until overwritten by the next load. Stores never modify it.
- start while busy (any state other than IDLE) is ignored. No queueing.
- A start in the same cycle as done is ignored. A start in the following IDLE cycle is accepted.
- stride=0 is legal: every beat uses the same address for all lanes. For stores, simultaneous same-address writes resolve per memory semantics; this block takes no action.
- Address wrap past 2^WIDTH-1 wraps silently. There is no error output.

Test Plan:
- Store: base=0, stride=1, elements 0..3 = 50,100,11,23, remaining elements = 1000+e, start at T0.
  - T0+1: mem_we=1, addr 0,1,2,3, wd 50,100,11,23.
  - Next three beats: addrs 4..15 with matching data.
  - done=1 at T0+5, mem_we=0 afterwards.
- Load back, RD_LAT=1, base=0, stride=1, memory model preloaded by the previous store.
  - T0+1: addrs 0..3, mem_we=0.
  - done at T0+6.
  - ld_data elements 0..3 = 50,100,11,23 and elements 4..15 = 1004..1015.
- Strided load: base=8, stride=4.
  - Beat 0 addrs 8,12,16,20; beat 3 addrs 56,60,64,68.
  - Repeat with RD_LAT=0: done at T0+5.
- Wrap and negative stride:
  - base=32'hFFFFFFFE, stride=1: beat 0 addrs FFFFFFFE, FFFFFFFF, 0, 1.
  - base=100, stride=32'hFFFFFFFF: beat 0 addrs 100,99,98,97.
- Start pulses at T0+2 and at the done cycle are both ignored. Only one done pulse occurs and the beat sequence is unchanged.
- rst_n=0 during beat 2 of a store:
  - mem_we and busy drop to 0 at once, with no further writes.
  - After release, a fresh load completes normally with ld_data previously cleared to 0.
